// File: rtl/microwave_control_pkg.sv
// Shared definitions for the microwave oven controller: FSM state codes and keypad limits.
// Display logic imports the same state codes so the debug state output decodes consistently.
package microwave_control_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SET   = 3'd1,
    ST_COOK  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [3:0] KEY_MAX = 4'd9;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= KEY_MAX;
  endfunction

endpackage

// File: rtl/microwave_control_sec_prescaler.sv
// One-second tick generator: pulses tick for one cycle every TICKS_PER_SEC cycles while run=1.
// restart zeroes the count; it is held whenever run is low.
module sec_prescaler #(
  parameter int unsigned TICKS_PER_SEC = 50_000_000
) (
  input  logic clock,
  input  logic clr,
  input  logic restart,
  input  logic run,
  output logic tick
);

  localparam int unsigned CW = $clog2(TICKS_PER_SEC);
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

  logic [CW-1:0] count_q, count_d;

  assign tick = run && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (restart) begin
      count_d = '0;
    end else if (run) begin
      count_d = tick ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/microwave_control.sv
// Oven sequencing FSM: turns keypad digits into timer load strobes, paces the countdown,
// gates the magnetron on door/start/stop and drives the done beeper.
module microwave_control
  import microwave_control_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 50_000_000,
  parameter int unsigned BEEP_SEC      = 3
) (
  input  logic       clock,
  input  logic       clr,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       start,
  input  logic       stop,
  input  logic       door_closed,
  input  logic       timer_zero,
  output logic [3:0] timer_data,
  output logic       timer_loadn,
  output logic       timer_clrn,
  output logic       timer_en,
  output logic       magnetron_on,
  output logic       done_beep,
  output logic [2:0] state
);

  localparam int unsigned BW = $clog2(BEEP_SEC + 1);

  logic [2:0]    state_q, state_d;
  logic [BW-1:0] beep_cnt_q, beep_cnt_d;
  logic [3:0]    timer_data_q, timer_data_d;
  logic          timer_loadn_q, timer_loadn_d;
  logic          timer_clrn_q, timer_clrn_d;
  logic          timer_en_q, timer_en_d;
  logic          magnetron_on_q, magnetron_on_d;
  logic          done_beep_q, done_beep_d;

  logic load, clear, digit_key, can_start;
  logic tick, ps_restart, ps_run;

  // The prescaler runs from state_q alone so tick never depends on the next-state decode.
  assign ps_run     = (state_q == ST_COOK) || (state_q == ST_DONE);
  assign ps_restart = ((state_d == ST_COOK) && (state_q != ST_COOK)) ||
                      ((state_d == ST_DONE) && (state_q != ST_DONE));

  sec_prescaler #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_prescaler (
    .clock   (clock),
    .clr     (clr),
    .restart (ps_restart),
    .run     (ps_run),
    .tick    (tick)
  );

  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      state_q        <= ST_IDLE;
      beep_cnt_q     <= '0;
      timer_data_q   <= 4'd0;
      timer_loadn_q  <= 1'b1;
      timer_clrn_q   <= 1'b0;
      timer_en_q     <= 1'b0;
      magnetron_on_q <= 1'b0;
      done_beep_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      beep_cnt_q     <= beep_cnt_d;
      timer_data_q   <= timer_data_d;
      timer_loadn_q  <= timer_loadn_d;
      timer_clrn_q   <= timer_clrn_d;
      timer_en_q     <= timer_en_d;
      magnetron_on_q <= magnetron_on_d;
      done_beep_q    <= done_beep_d;
    end
  end

  // Branch order encodes priority: stop, door open, timer_zero, start, key.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    clear     = 1'b0;
    digit_key = key_valid && is_digit(key_code);
    can_start = start && door_closed && !timer_zero;
    case (state_q)
      ST_IDLE: begin
        if (!stop) begin
          if (can_start) begin
            state_d = ST_COOK;
          end else if (digit_key) begin
            load    = 1'b1;
            state_d = ST_SET;
          end
        end
      end
      ST_SET: begin
        if (stop) begin
          clear   = 1'b1;
          state_d = ST_IDLE;
        end else if (can_start) begin
          state_d = ST_COOK;
        end else if (digit_key) begin
          load = 1'b1;
        end
      end
      ST_COOK: begin
        if (stop || !door_closed) begin
          state_d = ST_PAUSE;
        end else if (timer_zero) begin
          state_d = ST_DONE;
        end
      end
      ST_PAUSE: begin
        if (stop) begin
          clear   = 1'b1;
          state_d = ST_IDLE;
        end else if (start && door_closed) begin
          state_d = ST_COOK;
        end
      end
      ST_DONE: begin
        if (stop || (tick && (beep_cnt_q == BW'(BEEP_SEC - 1)))) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    beep_cnt_d = beep_cnt_q;
    if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
      beep_cnt_d = '0;
    end else if ((state_q == ST_DONE) && tick) begin
      beep_cnt_d = beep_cnt_q + 1'b1;
    end
    timer_data_d   = load ? key_code : timer_data_q;
    timer_loadn_d  = !load;
    timer_clrn_d   = !clear;
    timer_en_d     = tick && (state_q == ST_COOK) && (state_d == ST_COOK);
    magnetron_on_d = (state_d == ST_COOK);
    done_beep_d    = (state_d == ST_DONE);
  end

  assign timer_data   = timer_data_q;
  assign timer_loadn  = timer_loadn_q;
  assign timer_clrn   = timer_clrn_q;
  assign timer_en     = timer_en_q;
  assign magnetron_on = magnetron_on_q;
  assign done_beep    = done_beep_q;
  assign state        = state_q;

endmodule
